// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default word length.
package serial_adder_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder; the serial adder reuses this single cell for every bit position.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts operand bit pairs LSB first, builds the parallel sum and final carry,
// and pulses done for one cycle once WIDTH pairs have been accepted.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             bit_valid,
   input  logic             a,
   input  logic             b,
   output logic             busy,
   output logic             sum_bit,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             done
);

   localparam int                 CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

   state_t             r_state;
   state_t             w_next;
   logic               r_carry;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;
   logic               r_sum_bit;

   logic               w_clear;
   logic               w_accept;
   logic               w_last;
   logic               w_fa_s;
   logic               w_fa_cout;

   full_adder u_fa (
      .a    (a),
      .b    (b),
      .cin  (r_carry),
      .s    (w_fa_s),
      .cout (w_fa_cout)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_clear  = 1'b0;
      w_accept = 1'b0;
      w_last   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next  = RUN;
               w_clear = 1'b1;
            end
         end
         RUN: begin
            if (bit_valid) begin
               w_accept = 1'b1;
               if (r_cnt == LAST) begin
                  w_last = 1'b1;
                  w_next = DONE;
               end
            end
         end
         DONE: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Datapath: the start edge wipes the previous result; each accepted pair writes one sum bit.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_carry   <= 1'b0;
         r_cnt     <= '0;
         r_sum     <= '0;
         r_cout    <= 1'b0;
         r_sum_bit <= 1'b0;
      end else if (w_clear) begin
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else if (w_accept) begin
         r_carry      <= w_fa_cout;
         r_cnt        <= r_cnt + CNT_W'(1);
         r_sum[r_cnt] <= w_fa_s;
         r_sum_bit    <= w_fa_s;
         if (w_last) begin
            r_cout <= w_fa_cout;
         end
      end
   end

   assign busy    = (r_state == RUN);
   assign done    = (r_state == DONE);
   assign sum     = r_sum;
   assign cout    = r_cout;
   assign sum_bit = r_sum_bit;

   a_done_pulse: assert property (@(posedge clk) disable iff (!rstn) done |=> !done);
   a_busy_state: assert property (@(posedge clk) disable iff (!rstn) busy == (r_state == RUN));
   a_cnt_range:  assert property (@(posedge clk) disable iff (!rstn) (r_state == RUN) |-> (r_cnt <= LAST));

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: expected {cout,sum} words are queued at start and checked at done.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rstn;
   logic         start;
   logic         bit_valid;
   logic         a;
   logic         b;
   logic         busy;
   logic         sum_bit;
   logic [W-1:0] sum;
   logic         cout;
   logic         done;

   int           errors = 0;
   int           checks = 0;
   logic [W:0]   sb_q[$];
   logic         mdl_sum_bit;

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start),
      .bit_valid (bit_valid),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .sum_bit   (sum_bit),
      .sum       (sum),
      .cout      (cout),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_op(input logic [W-1:0] opa, input logic [W-1:0] opb);
      sb_q.push_back({1'b0, opa} + {1'b0, opb});
      start     = 1'b1;
      bit_valid = 1'b0;
      tick();
      chk("run_entry_busy", 32'(busy), 32'd1);
      chk("clear_sum", 32'(sum), 32'd0);
      chk("clear_cout", 32'(cout), 32'd0);
   endtask

   task automatic feed_bits(input logic [W-1:0] opa, input logic [W-1:0] opb,
                            input logic [W-1:0] stall, input logic keep_start);
      logic [W:0] exp;
      logic [W:0] popped;
      int         edges = 0;
      int         nst = 0;
      exp = {1'b0, opa} + {1'b0, opb};
      if (!keep_start) start = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (stall[i]) begin
            bit_valid = 1'b0;
            a = 1'($urandom);
            b = 1'($urandom);
            tick();
            edges++;
            nst++;
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_sum_bit", 32'(sum_bit), 32'(mdl_sum_bit));
            chk("stall_done", 32'(done), 32'd0);
         end
         bit_valid = 1'b1;
         a = opa[i];
         b = opb[i];
         tick();
         edges++;
         mdl_sum_bit = exp[i];
         chk("sum_bit", 32'(sum_bit), 32'(mdl_sum_bit));
         if (i < W - 1) chk("early_done", 32'(done), 32'd0);
      end
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("latency", 32'(edges), 32'(W + nst));
      if (sb_q.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         popped = sb_q.pop_front();
         chk("result", 32'({cout, sum}), 32'(popped));
      end
      // bit_valid during DONE must be ignored
      bit_valid = 1'b1;
      a = 1'b1;
      b = 1'b1;
      tick();
      bit_valid = 1'b0;
      chk("done_single", 32'(done), 32'd0);
      chk("back_idle", 32'(busy), 32'd0);
      chk("hold_result", 32'({cout, sum}), 32'(exp));
      chk("hold_sum_bit", 32'(sum_bit), 32'(mdl_sum_bit));
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [W-1:0] rs;
      rstn = 1'b0;
      start = 1'b1;
      bit_valid = 1'b0;
      a = 1'b0;
      b = 1'b0;
      mdl_sum_bit = 1'b0;
      repeat (2) tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum_bit", 32'(sum_bit), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      start = 1'b0;
      rstn = 1'b1;
      tick();

      begin_op(8'd3, 8'd5);
      feed_bits(8'd3, 8'd5, 8'h00, 1'b0);

      bit_valid = 1'b1;
      a = 1'b1;
      b = 1'b1;
      repeat (2) tick();
      bit_valid = 1'b0;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_sum", 32'(sum), 32'h08);
      chk("idle_cout", 32'(cout), 32'd0);
      chk("idle_sum_bit", 32'(sum_bit), 32'(mdl_sum_bit));

      begin_op(8'hFF, 8'h01);
      feed_bits(8'hFF, 8'h01, 8'h00, 1'b0);

      begin_op(8'hA5, 8'h5A);
      feed_bits(8'hA5, 8'h5A, 8'hFF, 1'b0);

      // abort a word after four bits with an asynchronous reset
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bit_valid = 1'b1;
         a = 1'b1;
         b = 1'b0;
         tick();
         mdl_sum_bit = 1'b1;
         chk("abort_sum_bit", 32'(sum_bit), 32'(mdl_sum_bit));
      end
      bit_valid = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      mdl_sum_bit = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_sum_bit", 32'(sum_bit), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
      rstn = 1'b1;
      begin_op(8'd1, 8'd1);
      feed_bits(8'd1, 8'd1, 8'h00, 1'b0);

      // start held high through a whole word, then a second word starts right after IDLE
      begin_op(8'h80, 8'h80);
      feed_bits(8'h80, 8'h80, 8'h00, 1'b1);
      tick();
      chk("restart_busy", 32'(busy), 32'd1);
      chk("restart_sum", 32'(sum), 32'd0);
      chk("restart_cout", 32'(cout), 32'd0);
      sb_q.push_back({1'b0, 8'h12} + {1'b0, 8'h34});
      feed_bits(8'h12, 8'h34, 8'h24, 1'b0);

      for (int k = 0; k < 4; k++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rs = W'($urandom);
         begin_op(ra, rb);
         feed_bits(ra, rb, rs, 1'b0);
      end

      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result word length in bits (legal range 1..32).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port rstn  input  1  reset that is asynchronous and active-low.
REQ-004 The block SHALL have port start  input  1  begin a new addition, sampled only in IDLE.
REQ-005 The block SHALL have port bit_valid  input  1  qualifies a and b as the next operand bit pair, LSB first.
REQ-006 The block SHALL have port a  input  1  operand A serial bit.
REQ-007 The block SHALL have port b  input  1  operand B serial bit.
REQ-008 The block SHALL have port busy  output  1  high while in RUN.
REQ-009 The block SHALL have port sum_bit  output  1  registered sum bit of the most recently accepted pair.
REQ-010 The block SHALL have port sum  output  WIDTH  assembled parallel result.
REQ-011 The block SHALL have port cout  output  1  final carry out of the word.
REQ-012 The block SHALL have port done  output  1  single-cycle completion pulse.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 IDLE with start=1 SHALL go to RUN next cycle; that edge SHALL clear the carry register, the bit counter, sum and cout.
REQ-015 IDLE with start=0 SHALL hold all state; bit_valid in IDLE SHALL be ignored.
REQ-016 In RUN, each cycle with bit_valid=1 SHALL accept one pair: s = a^b^carry, carry <= majority(a,b,carry), sum[cnt] <= s, sum_bit <= s, cnt <= cnt+1.
REQ-017 In RUN, bit_valid=0 SHALL stall: no change to carry, cnt, sum or sum_bit.
REQ-018 In RUN, start SHALL be ignored.
REQ-019 Accepting the pair at cnt==WIDTH-1 SHALL go to DONE, with cout <= carry-out of that bit.
REQ-020 DONE SHALL last exactly one cycle with done=1, then go to IDLE unconditionally; start and bit_valid in DONE SHALL be ignored.
REQ-021 sum and cout SHALL hold their final values after DONE until the next accepted start.
REQ-022 Latency SHALL be start-to-RUN 1 cycle, then exactly WIDTH accepted bit_valid cycles, then done asserted the cycle after the last accepted pair.
REQ-023 The result SHALL satisfy {cout,sum} == A+B modulo 2^(WIDTH+1).
REQ-024 The counter SHALL be $clog2(WIDTH+1) bits wide and never wrap within a word.

Reset
REQ-025 rstn=0 SHALL immediately force state IDLE, with busy=0, done=0, sum_bit=0, sum=0, cout=0, carry=0, cnt=0.
REQ-026 Reset asserted mid-RUN SHALL abandon the partial word without producing done.
REQ-027 After rstn deasserts, the first start SHALL be honoured on the first rising edge.

Structure
REQ-028 The state enum and the WIDTH default SHALL live in a shared package serial_adder_pkg.
REQ-029 The per-bit arithmetic SHALL be one combinational sub-module full_adder (a, b, cin -> s, cout) instantiated once.
REQ-030 The implementation SHALL include formal assertions: done is one-hot in time, busy==(state==RUN), and cnt<=WIDTH-1 while in RUN.

Verification
REQ-031 WIDTH=8, A=3, B=5, bit_valid continuous -> done on cycle 10 after start, sum=8'h08, cout=0.
REQ-032 A=8'hFF, B=8'h01 -> sum=8'h00, cout=1, sum_bit sequence 0,0,0,0,0,0,0,0.
REQ-033 A=8'hA5, B=8'h5A with bit_valid low on alternate cycles -> sum=8'hFF, cout=0, done 17 cycles after RUN entry.
REQ-034 rstn pulsed low after 4 accepted bits -> immediately busy=0, sum=0, no done; a new start then gives a correct result for A=1, B=1 (sum=8'h02).
REQ-035 start held high through an entire RUN with A=8'h80, B=8'h80 -> single operation, sum=8'h00, cout=1, then exactly one new RUN starting the cycle after DONE returns to IDLE.
